// File: rtl/sys_defs.sv
// Shared definitions for the FIR datapath: sizing constants, the stream bus
// type, and the arithmetic helpers used by the multiply and saturate stages.
package sys_defs;

  localparam int FIR_TAPS    = 16;
  localparam int SAMPLE_W    = 16;
  localparam int COEF_W      = 16;
  localparam int PROD_W      = 32;
  localparam int ACC_W       = 36;
  localparam int FIR_LATENCY = 5;

  // Stream bus: payload plus a qualifying valid bit.
  typedef struct packed {
    logic [31:0] data;
    logic        valid;
  } DATA_BUS;

  localparam logic signed [ACC_W-1:0] SAT_MAX = 36'sh07FFFFFFF;
  localparam logic signed [ACC_W-1:0] SAT_MIN = 36'shF80000000;

  // Full-precision signed 16x16 product.
  function automatic logic signed [PROD_W-1:0] mul16(
    input logic signed [SAMPLE_W-1:0] a,
    input logic signed [COEF_W-1:0]   b
  );
    logic signed [PROD_W-1:0] wa;
    logic signed [PROD_W-1:0] wb;
    wa = 32'(a);
    wb = 32'(b);
    return wa * wb;
  endfunction

  // Clip a 36-bit sum to signed 32 bits; MSB of the result is the clip flag.
  function automatic logic [32:0] saturate36(input logic signed [ACC_W-1:0] v);
    if (v > SAT_MAX) begin
      return {1'b1, 32'h7FFFFFFF};
    end else if (v < SAT_MIN) begin
      return {1'b1, 32'h80000000};
    end else begin
      return {1'b0, v[31:0]};
    end
  endfunction

endpackage

// File: rtl/fir_core_adder_tree.sv
// Four registered adder levels (33/34/35/36 bits) reducing 16 products to one
// saturated 32-bit result. The output register holds when no valid arrives.
module fir_adder_tree
  import sys_defs::*;
(
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [FIR_TAPS-1:0][PROD_W-1:0]  products,
  input  logic                             in_valid,
  output logic [31:0]                      sum,
  output logic                             sat,
  output logic                             out_valid
);

  logic signed [PROD_W:0]   lvl1 [8];
  logic signed [PROD_W+1:0] lvl2 [4];
  logic signed [PROD_W+2:0] lvl3 [2];
  logic                     v1;
  logic                     v2;
  logic                     v3;
  logic signed [ACC_W-1:0]  total;
  logic [32:0]              clipped;

  // First three reduction levels, each widened by one bit so nothing wraps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) lvl1[i] <= '0;
      for (int i = 0; i < 4; i++) lvl2[i] <= '0;
      for (int i = 0; i < 2; i++) lvl3[i] <= '0;
      v1 <= 1'b0;
      v2 <= 1'b0;
      v3 <= 1'b0;
    end else begin
      for (int i = 0; i < 8; i++)
        lvl1[i] <= 33'($signed(products[2*i])) + 33'($signed(products[2*i+1]));
      for (int i = 0; i < 4; i++)
        lvl2[i] <= 34'(lvl1[2*i]) + 34'(lvl1[2*i+1]);
      for (int i = 0; i < 2; i++)
        lvl3[i] <= 35'(lvl2[2*i]) + 35'(lvl2[2*i+1]);
      v1 <= in_valid;
      v2 <= v1;
      v3 <= v2;
    end
  end

  // Final 36-bit sum and its clipped form.
  always_comb begin
    total   = 36'(lvl3[0]) + 36'(lvl3[1]);
    clipped = saturate36(total);
  end

  // Output register: data and sat update only with a valid result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum       <= 32'd0;
      sat       <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= v3;
      if (v3) begin
        sum <= clipped[31:0];
        sat <= clipped[32];
      end
    end
  end

endmodule

// File: rtl/fir_core.sv
// 16-tap FIR core: delay line, coefficient bank with same-cycle write bypass,
// registered products, then the registered adder tree. Latency 5 cycles.
module fir_core
  import sys_defs::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  DATA_BUS           data_in,
  input  logic              coef_wr_en,
  input  logic [3:0]        coef_addr,
  input  logic [COEF_W-1:0] coef_data,
  output DATA_BUS           data_out,
  output logic              sat
);

  logic signed [SAMPLE_W-1:0]      taps     [FIR_TAPS];
  logic signed [COEF_W-1:0]        coefs    [FIR_TAPS];
  logic signed [SAMPLE_W-1:0]      window   [FIR_TAPS];
  logic signed [COEF_W-1:0]        eff_coef [FIR_TAPS];
  logic [FIR_TAPS-1:0][PROD_W-1:0] products;
  logic                            prod_valid;
  logic [31:0]                     tree_sum;
  logic                            tree_valid;

  // Window seen by the incoming sample, and coefficients with the pending
  // write bypassed so a sample sharing a cycle with a write uses the new value.
  always_comb begin
    window[0] = $signed(data_in.data[SAMPLE_W-1:0]);
    for (int k = 1; k < FIR_TAPS; k++) window[k] = taps[k-1];
    for (int k = 0; k < FIR_TAPS; k++) begin
      if (coef_wr_en && (coef_addr == 4'(k))) begin
        eff_coef[k] = $signed(coef_data);
      end else begin
        eff_coef[k] = coefs[k];
      end
    end
  end

  // Delay line shifts only on valid samples; unfilled taps stay zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < FIR_TAPS; k++) taps[k] <= '0;
    end else if (data_in.valid) begin
      for (int k = 0; k < FIR_TAPS; k++) taps[k] <= window[k];
    end
  end

  // Coefficient bank: last write to an address wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < FIR_TAPS; k++) coefs[k] <= '0;
    end else if (coef_wr_en) begin
      coefs[coef_addr] <= $signed(coef_data);
    end
  end

  // Product register, captured in the same edge as the delay line.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      products   <= '0;
      prod_valid <= 1'b0;
    end else begin
      for (int k = 0; k < FIR_TAPS; k++) products[k] <= mul16(window[k], eff_coef[k]);
      prod_valid <= data_in.valid;
    end
  end

  fir_adder_tree u_tree (
    .clk       (clk),
    .rst_n     (rst_n),
    .products  (products),
    .in_valid  (prod_valid),
    .sum       (tree_sum),
    .sat       (sat),
    .out_valid (tree_valid)
  );

  assign data_out.data  = tree_sum;
  assign data_out.valid = tree_valid;

endmodule

// File: tb/tb_fir_core.sv
// Self-checking bench for fir_core against a behavioural convolution model.
module tb_fir_core;
  import sys_defs::*;

  logic        clk;
  logic        rst_n;
  DATA_BUS     data_in;
  DATA_BUS     data_out;
  logic        coef_wr_en;
  logic [3:0]  coef_addr;
  logic [15:0] coef_data;
  logic        sat;

  int pass_cnt = 0;
  int check_cnt = 0;

  fir_core dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .data_in    (data_in),
    .coef_wr_en (coef_wr_en),
    .coef_addr  (coef_addr),
    .coef_data  (coef_data),
    .data_out   (data_out),
    .sat        (sat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: coefficient table, sample history, output pipe.
  typedef struct { bit v; logic [31:0] d; bit s; } ent_t;
  longint m_coef [16];
  longint m_hist [16];
  ent_t   m_pipe [$];
  logic [31:0] held_d;
  bit          held_s;
  bit          exp_v;
  logic [31:0] exp_d;
  bit          exp_s;

  task automatic model_reset();
    ent_t e;
    for (int k = 0; k < 16; k++) begin m_coef[k] = 0; m_hist[k] = 0; end
    m_pipe.delete();
    e.v = 1'b0; e.d = 32'd0; e.s = 1'b0;
    for (int i = 0; i < FIR_LATENCY - 1; i++) m_pipe.push_back(e);
    held_d = 32'd0; held_s = 1'b0;
    exp_v = 1'b0; exp_d = 32'd0; exp_s = 1'b0;
  endtask

  // One clock: drive inputs, advance model at the edge, settle for sampling.
  task automatic cycle(input bit v, input logic [15:0] x, input bit we,
                       input logic [3:0] a, input logic [15:0] c);
    ent_t e;
    ent_t o;
    longint acc;
    logic signed [15:0] xs;
    logic signed [15:0] cs;
    data_in.valid = v;
    data_in.data  = {16'($urandom), x};
    coef_wr_en = we; coef_addr = a; coef_data = c;
    @(posedge clk);
    if (rst_n) begin
      if (we) begin cs = c; m_coef[a] = longint'(cs); end
      e.v = v; e.d = 32'd0; e.s = 1'b0;
      if (v) begin
        for (int k = 15; k > 0; k--) m_hist[k] = m_hist[k-1];
        xs = x; m_hist[0] = longint'(xs);
        acc = 0;
        for (int k = 0; k < 16; k++) acc += m_coef[k] * m_hist[k];
        if (acc > 64'sh7FFFFFFF) begin e.d = 32'h7FFFFFFF; e.s = 1'b1; end
        else if (acc < -64'sh80000000) begin e.d = 32'h80000000; e.s = 1'b1; end
        else e.d = acc[31:0];
      end
      m_pipe.push_back(e);
      o = m_pipe.pop_front();
      if (o.v) begin held_d = o.d; held_s = o.s; end
      exp_v = o.v; exp_d = held_d; exp_s = held_s;
    end
    #1;
    data_in.valid = 1'b0;
    coef_wr_en = 1'b0;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    model_reset();
    #1;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    model_reset();
    #2;
    check_cnt++;
    if ({data_out.valid, data_out.data, sat} !== 34'd0)
      $display("FAIL reset_async: got v=%0b d=%h s=%0b, expected all 0", data_out.valid, data_out.data, sat);
    else pass_cnt++;
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 16'd0, 1'b0, 4'd0, 16'd0);
      check_cnt++;
      if ({data_out.valid, data_out.data, sat} !== 34'd0)
        $display("FAIL reset_after: got v=%0b d=%h s=%0b, expected all 0", data_out.valid, data_out.data, sat);
      else pass_cnt++;
    end
  endtask

  task automatic test_impulse();
    logic [31:0] want;
    apply_reset();
    for (int k = 0; k < 16; k++) cycle(1'b0, 16'd0, 1'b1, 4'(k), 16'(k + 1));
    for (int i = 0; i < 27; i++) begin
      cycle(i <= 20, (i == 0) ? 16'd1 : 16'd0, 1'b0, 4'd0, 16'd0);
      check_cnt++;
      if ({data_out.valid, data_out.data, sat} !== {exp_v, exp_d, exp_s})
        $display("FAIL impulse_model c%0d: got v=%0b d=%h s=%0b, expected v=%0b d=%h s=%0b",
                 i, data_out.valid, data_out.data, sat, exp_v, exp_d, exp_s);
      else pass_cnt++;
      if (i == 3 || (i >= 4 && i <= 24)) begin
        want = (i >= 4 && i - 4 < 16) ? 32'(i - 3) : 32'd0;
        check_cnt++;
        if (data_out.valid !== (i >= 4) || (i >= 4 && data_out.data !== want))
          $display("FAIL impulse_const c%0d: got v=%0b d=%h, expected v=%0b d=%h",
                   i, data_out.valid, data_out.data, i >= 4, want);
        else pass_cnt++;
      end
    end
  endtask

  task automatic test_saturation();
    logic [15:0] c_tab [4] = '{16'h7FFF, 16'h8000, 16'h7FFF, 16'h0001};
    logic [15:0] x_tab [4] = '{16'h7FFF, 16'h8000, 16'h8000, 16'hFFFB};
    int          n_tab [4] = '{16, 16, 16, 1};
    logic [31:0] d_tab [4] = '{32'h7FFFFFFF, 32'h7FFFFFFF, 32'h80000000, 32'hFFFFFFFB};
    bit          s_tab [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    int nout;
    for (int t = 0; t < 4; t++) begin
      apply_reset();
      for (int k = 0; k < 16; k++)
        cycle(1'b0, 16'd0, (t < 3) || (k == 0), 4'(k), c_tab[t]);
      nout = 0;
      for (int i = 0; i < n_tab[t] + 6; i++) begin
        cycle(i < n_tab[t], x_tab[t], 1'b0, 4'd0, 16'd0);
        check_cnt++;
        if ({data_out.valid, data_out.data, sat} !== {exp_v, exp_d, exp_s})
          $display("FAIL sat_model t%0d c%0d: got v=%0b d=%h s=%0b, expected v=%0b d=%h s=%0b",
                   t, i, data_out.valid, data_out.data, sat, exp_v, exp_d, exp_s);
        else pass_cnt++;
        if (data_out.valid) begin
          nout++;
          if (nout == n_tab[t]) begin
            check_cnt++;
            if ({data_out.data, sat} !== {d_tab[t], s_tab[t]})
              $display("FAIL sat_const t%0d: got d=%h s=%0b, expected d=%h s=%0b",
                       t, data_out.data, sat, d_tab[t], s_tab[t]);
            else pass_cnt++;
          end
        end
      end
    end
  endtask

  task automatic test_bubbles();
    bit          pat [7]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    logic [15:0] xs  [4]  = '{16'd3, 16'd4, 16'd5, 16'd6};
    logic [31:0] ys  [4]  = '{32'd3, 32'd7, 32'd9, 32'd11};
    int xi;
    int yi;
    bit want_v;
    apply_reset();
    cycle(1'b0, 16'd0, 1'b1, 4'd0, 16'd1);
    cycle(1'b0, 16'd0, 1'b1, 4'd1, 16'd1);
    xi = 0; yi = 0;
    for (int i = 0; i < 13; i++) begin
      if (i < 7 && pat[i]) begin cycle(1'b1, xs[xi], 1'b0, 4'd0, 16'd0); xi++; end
      else cycle(1'b0, 16'd0, 1'b0, 4'd0, 16'd0);
      want_v = (i >= 4 && i - 4 < 7) ? pat[i-4] : 1'b0;
      check_cnt++;
      if (data_out.valid !== want_v || (want_v && data_out.data !== ys[yi]))
        $display("FAIL bubbles c%0d: got v=%0b d=%h, expected v=%0b d=%h",
                 i, data_out.valid, data_out.data, want_v, want_v ? ys[yi] : data_out.data);
      else pass_cnt++;
      if (want_v && yi < 3) yi++;
    end
  endtask

  task automatic test_coef_timing();
    int nout;
    apply_reset();
    cycle(1'b0, 16'd0, 1'b1, 4'd0, 16'd1);
    cycle(1'b1, 16'd10, 1'b1, 4'd0, 16'd2);
    cycle(1'b1, 16'd10, 1'b0, 4'd0, 16'd0);
    nout = 0;
    for (int i = 0; i < 6; i++) begin
      cycle(1'b0, 16'd0, 1'b0, 4'd0, 16'd0);
      if (data_out.valid) begin
        nout++;
        check_cnt++;
        if (data_out.data !== 32'd20)
          $display("FAIL coef_timing out%0d: got d=%h, expected d=%h", nout, data_out.data, 32'd20);
        else pass_cnt++;
      end
    end
    check_cnt++;
    if (nout !== 2) $display("FAIL coef_timing_count: got %0d outputs, expected 2", nout);
    else pass_cnt++;
  endtask

  task automatic test_reset_midstream();
    int nvalid;
    apply_reset();
    for (int k = 0; k < 16; k++) cycle(1'b0, 16'd0, 1'b1, 4'(k), 16'($urandom_range(1, 1000)));
    for (int i = 0; i < 3; i++) cycle(1'b1, 16'($urandom_range(1, 1000)), 1'b0, 4'd0, 16'd0);
    rst_n = 1'b0;
    model_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
    nvalid = 0;
    for (int i = 0; i < 8; i++) begin
      cycle(1'b0, 16'd0, 1'b0, 4'd0, 16'd0);
      if (data_out.valid || data_out.data !== 32'd0 || sat) nvalid++;
    end
    check_cnt++;
    if (nvalid !== 0) $display("FAIL midreset_flush: got %0d nonzero cycles, expected 0", nvalid);
    else pass_cnt++;
    for (int i = 0; i < 8; i++) begin
      cycle(i < 2, 16'h1234, 1'b0, 4'd0, 16'd0);
      check_cnt++;
      if ({data_out.valid, data_out.data, sat} !== {exp_v, 32'd0, 1'b0} || data_out.valid !== (i == 4 || i == 5))
        $display("FAIL midreset_zero c%0d: got v=%0b d=%h s=%0b, expected v=%0b d=0 s=0",
                 i, data_out.valid, data_out.data, sat, (i == 4 || i == 5));
      else pass_cnt++;
    end
  endtask

  task automatic test_random();
    bit v;
    bit we;
    logic [15:0] x;
    apply_reset();
    for (int i = 0; i < 400; i++) begin
      v  = ($urandom_range(0, 3) != 0);
      we = ($urandom_range(0, 4) == 0) || (i < 16);
      case ($urandom_range(0, 5))
        0: x = 16'h7FFF;
        1: x = 16'h8000;
        default: x = 16'($urandom);
      endcase
      cycle(v, x, we, (i < 16) ? 4'(i) : 4'($urandom), ($urandom_range(0, 3) == 0) ? 16'h7FFF : 16'($urandom));
      check_cnt++;
      if ({data_out.valid, data_out.data, sat} !== {exp_v, exp_d, exp_s})
        $display("FAIL random c%0d: got v=%0b d=%h s=%0b, expected v=%0b d=%h s=%0b",
                 i, data_out.valid, data_out.data, sat, exp_v, exp_d, exp_s);
      else pass_cnt++;
    end
  endtask

  initial begin
    rst_n = 1'b0;
    data_in = '0;
    coef_wr_en = 1'b0;
    coef_addr = 4'd0;
    coef_data = 16'd0;
    test_reset();
    test_impulse();
    test_saturation();
    test_bubbles();
    test_coef_timing();
    test_reset_midstream();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule

// File: doc/fir_core.md
FIR_CORE -- requirements
Module: fir_core

Interface
REQ-001 SHALL have a single clock and an asynchronous, active-low reset.
REQ-002 clk  input  1  system clock; all state changes on its rising edge.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 data_in  input  DATA_BUS  sample stream (.data 32, .valid 1); sample = signed data[15:0]; data[31:16] ignored.
REQ-005 coef_wr_en  input  1  coefficient write strobe.
REQ-006 coef_addr  input  4  tap index 0..15 for the write.
REQ-007 coef_data  input  16  signed coefficient value.
REQ-008 data_out  output  DATA_BUS  filtered stream (.data signed 32, .valid 1).
REQ-009 sat  output  1  high with data_out.valid when that output was clipped.

Function
REQ-010 SHALL compute y[n] = sum over k=0..15 of c[k]*x[n-k], where x[n] is the newest valid sample and c[k] the tap-k coefficient.
REQ-011 Delay line: 16 x 16-bit registers; SHALL shift by one only in cycles with data_in.valid=1 (tap0 <- sample, tap k <- tap k-1); invalid cycles leave it unchanged.
REQ-012 Taps not yet filled since reset SHALL contribute 0; one output SHALL be produced for every input sample, with no warm-up suppression.
REQ-013 Pipeline: delay-line capture, registered 16 products (32-bit signed), then 4 registered adder levels (33, 34, 35, 36 bits) with saturation in the last level.
REQ-014 Latency SHALL be exactly 5 cycles: valid input in cycle n -> data_out.valid in cycle n+5; a valid bit travels with each stage.
REQ-015 Accepts one sample per cycle with no stalls; bubbles in the input SHALL appear as identical bubbles in the output.
REQ-016 Accumulation SHALL be full precision at 36 bits; no intermediate truncation or wrap.
REQ-017 Output SHALL be the 36-bit sum saturated to signed 32 bits: >0x7FFFFFFF -> 0x7FFFFFFF; <-0x80000000 -> 0x80000000; sat=1 exactly in those cases.
REQ-018 When data_out.valid=0, data_out.data and sat SHALL hold their last values; sat is meaningful only with valid.
REQ-019 Coefficient write in cycle n SHALL update c[coef_addr] at the edge ending cycle n; a sample presented in cycle m uses every write from cycles <= m and none from later cycles.
REQ-020 Simultaneous coef write and valid sample in the same cycle SHALL be legal, and that sample SHALL use the new coefficient.
REQ-021 Repeated writes to one address: the last write wins; other taps are unaffected.

Reset
REQ-022 rst_n=0 SHALL asynchronously clear the delay line, all coefficients, and all pipeline data and valid registers.
REQ-023 During and after reset: data_out.valid=0, data_out.data=0, sat=0.
REQ-024 Reset mid-stream SHALL discard all in-flight samples: no output valid is produced for samples accepted before reset, and coefficients read 0 until rewritten.
REQ-025 The first sample after rst_n deasserts SHALL be accepted in the first cycle in which rst_n=1 at the rising edge.

Structure
REQ-026 FIR_TAPS=16, SAMPLE_W=16, COEF_W=16, ACC_W=36 and FIR_LATENCY=5 SHALL live in the shared sys_defs package beside DATA_BUS.
REQ-027 The 4-level registered adder tree plus saturation SHALL be one sub-module, fir_adder_tree (16 x 32-bit in with valid, 32-bit out plus sat plus valid).
REQ-028 fir_core SHALL connect directly to the output of the input buffering stage; no handshake beyond valid.

Verification
REQ-029 Impulse: c[k]=k+1; inputs 1 then 20 zeros, back to back -> outputs 1,2,...,16, then 0s; first output exactly 5 cycles after the impulse.
REQ-030 Positive saturation: all c=0x7FFF, 16 samples of 0x7FFF -> 16th output 0x7FFFFFFF with sat=1; 0x8000 x 0x8000 on all taps -> 0x7FFFFFFF, sat=1.
REQ-031 Negative saturation: all c=0x7FFF, 16 samples of 0x8000 (sum -0x3FFF80000) -> 0x80000000, sat=1; c=1, x=-5 on one tap -> 0xFFFFFFFB, sat=0.
REQ-032 Bubbles: c[0]=1, c[1]=1; valid pattern 1,0,0,1,1,0,1 with x=3,4,5,6 -> outputs 3,7,9,11; valid pattern delayed 5 cycles.
REQ-033 Coefficient timing: c[0]=1; in the same cycle write c[0]=2 and send x=10, then send x=10 -> outputs 20, 20 (c[1]=0).
REQ-034 Reset mid-stream: assert rst_n for 1 cycle with 3 samples in flight -> no output valid afterwards until new input; all outputs 0 until coefficients are rewritten.
